axis_upsizer_arbiter: RTL and testbench
=======================================

# axis_upsizer_arbiter

Round-robin arbiter that shares one `axis_upsizer` between several narrow AXI4-Stream sources. It grants one source at a time and holds the grant for exactly one upsizer frame of `cfg_data+1` narrow words. Words from different sources therefore never mix inside one wide output word. It sits directly in front of the upsizer, and both blocks are driven from the same `cfg_data`.

## Interface
Parameters:
- `S_AXIS_TDATA_WIDTH`, 32, width of each source stream and of the output stream
- `N_INPUTS`, 4, number of sources (2..16)
- `ID_WIDTH`, `$clog2(N_INPUTS)`, width of `m_axis_tid` (min 1)

Ports:
- `aclk`  in  1  clock
- `areset`  in  1  asynchronous, active-high reset
- `cfg_data`  in  16  narrow words per frame minus 1; same value as fed to the upsizer
- `s_axis_tdata`  in  N_INPUTS*S_AXIS_TDATA_WIDTH  flattened source data, source i at bits [i*W +: W]
- `s_axis_tvalid`  in  N_INPUTS  per-source valid
- `s_axis_tready`  out  N_INPUTS  per-source ready
- `m_axis_tdata`  out  S_AXIS_TDATA_WIDTH  data to the upsizer
- `m_axis_tvalid`  out  1  valid to the upsizer
- `m_axis_tready`  in  1  ready from the upsizer
- `m_axis_tid`  out  ID_WIDTH  index of the granted source
- `m_axis_tlast`  out  1  high on the final word of a frame
- `busy`  out  1  high while a grant is held

## Operation
- Two states: IDLE and GRANT.
- **IDLE:**
  - `m_axis_tvalid` and all `s_axis_tready` are 0.
  - If any `s_axis_tvalid` is 1, pick the winner, register its index into `grant_reg`, latch `cfg_data` into `len_reg`, clear `cnt_reg`, and go to GRANT.
- **GRANT:** pass-through for source `grant_reg`:
  - `m_axis_tdata` = source data; `m_axis_tvalid` = source valid.
  - `s_axis_tready[grant_reg]` = `m_axis_tready`; all other readies are 0.
  - A beat is `m_axis_tvalid & m_axis_tready`. Each beat increments the 16-bit `cnt_reg`.
  - `m_axis_tlast` = (`cnt_reg == len_reg`) & `m_axis_tvalid`.
  - The beat with `cnt_reg == len_reg` ends the frame. On that beat, set `last_reg` = `grant_reg` and go to IDLE.
- **Round-robin:** search starts at `last_reg+1` and wraps modulo `N_INPUTS`. The first source with tvalid=1 wins.
- `cfg_data` changes during GRANT are ignored; the new value takes effect at the next grant. The upsizer must see a stable `cfg_data` per frame, so system software changes it only while `busy`=0.
- `cfg_data` = 0 gives 1-word frames, with `m_axis_tlast` on every beat.
- While granted, the block waits for the source indefinitely. A source stalling mid-frame holds the grant (no timeout).
- **Reset values** (immediate, asynchronous):
  - State IDLE, `m_axis_tvalid`=0, `s_axis_tready`=0, `m_axis_tlast`=0, `busy`=0.
  - `m_axis_tid`=0, `cnt_reg`=0, `len_reg`=0.
  - `last_reg`=`N_INPUTS-1`, so source 0 has first priority.
- **Reset mid-frame:** the partial frame is abandoned. The upsizer must share this reset (`aresetn` = ~`areset`) so its word counter also realigns.

## Timing
- Arbitration costs 1 cycle: source valid rises in cycle n, and `m_axis_tvalid` can be high in cycle n+1.
- After a frame ends there is exactly one IDLE bubble cycle before the next grant.
- Throughput for frames of L words with continuous valid/ready: L beats per L+1 cycles.
- Data path is combinational in GRANT (zero latency, no register stage).
- `m_axis_tid` and `busy` are registered and stable for the entire frame.
- `m_axis_tid` holds its last value through IDLE.

## Configuration
- `AXIS_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. The search always starts at source 0, so the lowest active index wins and `last_reg` is unused.
  - Undefined (default): round-robin as described above.

## Test plan
- **Single source:** `cfg_data`=2, source 1 streams 0xA0..0xA5 with `m_axis_tready`=1.
  - Expect two frames of 3 beats, `tid`=1.
  - `tlast` on 0xA2 and 0xA5.
  - One bubble cycle between frames.
- **Round-robin fairness:** `cfg_data`=0, all 4 sources always valid.
  - Grant order is 0,1,2,3,0,…
  - With `AXIS_ARB_FIXED_PRIO_EN` defined, the grant is always 0.
- **Backpressure:** `cfg_data`=3, toggle `m_axis_tready` every cycle.
  - Exactly 4 beats per frame.
  - Non-granted sources see tready=0 throughout.
  - No data is lost or duplicated.
- **Config change mid-frame:** `cfg_data`=3, change it to 1 after beat 2.
  - The current frame still ends after 4 beats.
  - The next frame is 2 beats.
- **Source stall:** the granted source drops tvalid for 10 cycles mid-frame while source 2 is valid.
  - The grant is held, `busy`=1, and source 2 stays at tready=0.
  - The frame resumes and completes.
- **Reset mid-frame:** assert `areset` after beat 1 of 4.
  - All outputs go to reset values immediately.
  - After release with sources 0 and 3 valid, source 0 is granted first.

Source files
------------

// File: rtl/axis_upsizer_arbiter.sv
// axis_upsizer_arbiter: shares one AXI4-Stream upsizer between N_INPUTS narrow
// sources, holding each grant for one frame of cfg_data+1 words.
//
// Ports:
//   aclk, areset      clock, async active-high reset
//   cfg_data          words per frame minus 1, latched at grant
//   s_axis_tdata      flattened source data, source i at [i*W +: W]
//   s_axis_tvalid     per-source valid
//   s_axis_tready     per-source ready (granted source only)
//   m_axis_tdata      data to upsizer (combinational pass-through)
//   m_axis_tvalid     valid to upsizer
//   m_axis_tready     ready from upsizer
//   m_axis_tid        index of granted source (registered)
//   m_axis_tlast      high on final word of a frame
//   busy              high while a grant is held (registered)
//
// Build option: define AXIS_ARB_FIXED_PRIO_EN for fixed priority (lowest
// active index wins); default is round-robin.

module axis_upsizer_arbiter #(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int N_INPUTS           = 4,
  parameter int ID_WIDTH           = $clog2(N_INPUTS)
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [15:0]                        cfg_data,
  input  logic [N_INPUTS*S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_INPUTS-1:0]                s_axis_tvalid,
  output logic [N_INPUTS-1:0]                s_axis_tready,
  output logic [S_AXIS_TDATA_WIDTH-1:0]      m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [ID_WIDTH-1:0]                m_axis_tid,
  output logic                               m_axis_tlast,
  output logic                               busy
);

  localparam int W = S_AXIS_TDATA_WIDTH;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t              r_state;
  logic [ID_WIDTH-1:0] r_grant;
  logic [15:0]         r_len;
  logic [15:0]         r_cnt;
  logic                r_busy;

  logic [ID_WIDTH-1:0] w_start;
  logic [ID_WIDTH-1:0] w_win;
  logic                w_found;
  logic [W-1:0]        w_data;
  logic                w_valid;
  logic [N_INPUTS-1:0] w_ready;
  logic                w_beat;
  logic                w_end;

  // Search start point for the next grant.
`ifdef AXIS_ARB_FIXED_PRIO_EN
  always_comb begin
    w_start = '0;
  end
`else
  logic [ID_WIDTH-1:0] r_last;

  always_comb begin
    if (r_last == ID_WIDTH'(N_INPUTS - 1)) begin
      w_start = '0;
    end else begin
      w_start = r_last + ID_WIDTH'(1);
    end
  end
`endif

  // Winner = valid source with the smallest circular distance from w_start.
  always_comb begin
    int best;
    int d;
    best    = N_INPUTS;
    d       = 0;
    w_win   = '0;
    w_found = |s_axis_tvalid;
    for (int i = 0; i < N_INPUTS; i++) begin
      d = i - int'(w_start);
      if (d < 0) begin
        d = d + N_INPUTS;
      end
      if (s_axis_tvalid[i] && (d < best)) begin
        best  = d;
        w_win = ID_WIDTH'(i);
      end
    end
  end

  // Zero-latency pass-through of the granted source.
  always_comb begin
    w_data  = '0;
    w_valid = 1'b0;
    w_ready = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if ((r_state == ST_GRANT) && (r_grant == ID_WIDTH'(i))) begin
        w_data     = s_axis_tdata[i*W +: W];
        w_valid    = s_axis_tvalid[i];
        w_ready[i] = m_axis_tready;
      end
    end
  end

  assign w_beat = w_valid & m_axis_tready;
  assign w_end  = (r_cnt == r_len);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
      r_last  <= ID_WIDTH'(N_INPUTS - 1);
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_win;
            r_len   <= cfg_data;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 16'd1;
            if (w_end) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
`ifndef AXIS_ARB_FIXED_PRIO_EN
              r_last  <= r_grant;
`endif
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready = w_ready;
  assign m_axis_tdata  = w_data;
  assign m_axis_tvalid = w_valid;
  assign m_axis_tlast  = w_end & w_valid;
  assign m_axis_tid    = r_grant;
  assign busy          = r_busy;

endmodule

// File: tb/tb_axis_upsizer_arbiter.sv
// tb_axis_upsizer_arbiter: directed self-checking bench for
// axis_upsizer_arbiter (4 sources, 32-bit data).

module tb_axis_upsizer_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic [15:0]    cfg_data;
  logic [N*W-1:0] s_axis_tdata;
  logic [N-1:0]   s_axis_tvalid;
  logic [N-1:0]   s_axis_tready;
  logic [W-1:0]   m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [1:0]     m_axis_tid;
  logic           m_axis_tlast;
  logic           busy;

  axis_upsizer_arbiter #(
    .S_AXIS_TDATA_WIDTH(W),
    .N_INPUTS(N),
    .ID_WIDTH(2)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_data(cfg_data),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tid(m_axis_tid),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

`ifdef AXIS_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  int         src_cnt[N];
  logic [W-1:0] src_dat[N];
  logic [N-1:0] stall;
  logic       tog;
  int         cyc_num;
  logic       bad_rdy;

  logic [W-1:0] q_data[$];
  logic [1:0]   q_tid[$];
  logic         q_last[$];
  int           q_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i]        = (src_cnt[i] > 0) && !stall[i];
      s_axis_tdata[i*W +: W]  = src_dat[i];
    end
  endtask

  // One clock: sample at negedge, advance source model just after posedge.
  task automatic cyc();
    logic [N-1:0] hs;
    @(negedge aclk);
    hs = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_tid.push_back(m_axis_tid);
      q_last.push_back(m_axis_tlast);
      q_cyc.push_back(cyc_num);
    end
    if (($countones(s_axis_tready) > 1) ||
        ((s_axis_tready != '0) && !s_axis_tready[m_axis_tid]))
      bad_rdy = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        src_cnt[i]--;
        src_dat[i]++;
      end
    end
    if (tog) m_axis_tready = ~m_axis_tready;
    cyc_num++;
    drive();
  endtask

  task automatic run_until(input int n, input int maxc, input string tag);
    int k;
    k = 0;
    while ((q_data.size() < n) && (k < maxc)) begin
      cyc();
      k++;
    end
    chk(tag, q_data.size(), n);
  endtask

  task automatic clr_q();
    q_data.delete();
    q_tid.delete();
    q_last.delete();
    q_cyc.delete();
    cyc_num = 0;
    bad_rdy = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_cnt[i] = 0;
      src_dat[i] = '0;
    end
    stall = '0;
    tog = 1'b0;
    m_axis_tready = 1'b1;
    drive();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    clr_q();
  endtask

  initial begin
    int src;
    int wd;
    logic stall_bad;
    cfg_data = 16'd0;
    m_axis_tready = 1'b1;
    stall = '0;
    tog = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_cnt[i] = 0;
      src_dat[i] = '0;
    end
    src_cnt[2] = 1;
    drive();
    clr_q();

    // Reset state with a source requesting
    #2;
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_sready", s_axis_tready, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tid", m_axis_tid, 0);

    // Single source, 3-word frames
    do_reset();
    cfg_data = 16'd2;
    src_cnt[1] = 6;
    src_dat[1] = 32'hA0;
    drive();
    run_until(6, 40, "t1_timeout");
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("t1_data%0d", j), q_data[j], 32'hA0 + j);
      chk($sformatf("t1_tid%0d", j), q_tid[j], 1);
      chk($sformatf("t1_last%0d", j), q_last[j], (j == 2) || (j == 5));
    end
    chk("t1_latency", q_cyc[0], 1);
    chk("t1_back2back", q_cyc[2] - q_cyc[0], 2);
    chk("t1_bubble", q_cyc[3] - q_cyc[2], 2);
    cyc();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_valid", m_axis_tvalid, 0);
    chk("t1_idle_tid", m_axis_tid, 1);

    // Round-robin fairness, 1-word frames
    do_reset();
    cfg_data = 16'd0;
    for (int i = 0; i < N; i++) begin
      src_cnt[i] = 100;
      src_dat[i] = 32'h100 * i;
    end
    drive();
    run_until(8, 40, "t2_timeout");
    for (int j = 0; j < 8; j++) begin
      src = FIXED ? 0 : (j % 4);
      wd  = FIXED ? j : (j / 4);
      chk($sformatf("t2_tid%0d", j), q_tid[j], src);
      chk($sformatf("t2_data%0d", j), q_data[j], 32'h100 * src + wd);
      chk($sformatf("t2_last%0d", j), q_last[j], 1);
    end
    chk("t2_spacing", q_cyc[5] - q_cyc[4], 2);

    // Backpressure with toggling ready
    do_reset();
    cfg_data = 16'd3;
    src_cnt[0] = 8;
    src_dat[0] = 32'hB00;
    src_cnt[2] = 8;
    src_dat[2] = 32'hC00;
    tog = 1'b1;
    drive();
    run_until(16, 200, "t3_timeout");
    for (int j = 0; j < 16; j++) begin
      if (FIXED) begin
        src = (j < 8) ? 0 : 2;
        wd  = j % 8;
      end else begin
        src = ((j / 4) % 2 == 0) ? 0 : 2;
        wd  = (j / 8) * 4 + (j % 4);
      end
      chk($sformatf("t3_tid%0d", j), q_tid[j], src);
      chk($sformatf("t3_data%0d", j), q_data[j],
          ((src == 0) ? 32'hB00 : 32'hC00) + wd);
      chk($sformatf("t3_last%0d", j), q_last[j], (j % 4) == 3);
    end
    chk("t3_ready_excl", bad_rdy, 0);

    // Config change mid-frame
    do_reset();
    cfg_data = 16'd3;
    src_cnt[1] = 8;
    src_dat[1] = 32'hD0;
    drive();
    run_until(2, 20, "t4_timeout_a");
    cfg_data = 16'd1;
    run_until(6, 40, "t4_timeout_b");
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("t4_data%0d", j), q_data[j], 32'hD0 + j);
      chk($sformatf("t4_last%0d", j), q_last[j], (j == 3) || (j == 5));
    end

    // Granted source stalls while another source waits
    do_reset();
    cfg_data = 16'd3;
    src_cnt[0] = 4;
    src_dat[0] = 32'hE0;
    src_cnt[2] = 4;
    src_dat[2] = 32'hF0;
    drive();
    run_until(2, 20, "t5_timeout_a");
    stall[0] = 1'b1;
    drive();
    stall_bad = 1'b0;
    repeat (10) begin
      cyc();
      if (!busy || (m_axis_tid != 2'd0) || s_axis_tready[2] || m_axis_tvalid)
        stall_bad = 1'b1;
    end
    chk("t5_stall_hold", stall_bad, 0);
    chk("t5_stall_nobeat", q_data.size(), 2);
    stall[0] = 1'b0;
    drive();
    run_until(8, 40, "t5_timeout_b");
    chk("t5_tid3", q_tid[3], 0);
    chk("t5_data3", q_data[3], 32'hE3);
    chk("t5_last3", q_last[3], 1);
    chk("t5_tid4", q_tid[4], 2);
    chk("t5_data4", q_data[4], 32'hF0);
    chk("t5_data7", q_data[7], 32'hF3);

    // Reset mid-frame
    do_reset();
    cfg_data = 16'd3;
    src_cnt[1] = 8;
    src_dat[1] = 32'h50;
    drive();
    run_until(1, 20, "t6_timeout_a");
    chk("t6_busy_pre", busy, 1);
    chk("t6_valid_pre", m_axis_tvalid, 1);
    #2;
    areset = 1'b1;
    #1;
    chk("t6_rst_mvalid", m_axis_tvalid, 0);
    chk("t6_rst_sready", s_axis_tready, 0);
    chk("t6_rst_tlast", m_axis_tlast, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tid", m_axis_tid, 0);
    src_cnt[1] = 0;
    src_cnt[0] = 2;
    src_dat[0] = 32'h10;
    src_cnt[3] = 2;
    src_dat[3] = 32'h30;
    drive();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    clr_q();
    run_until(1, 10, "t6_timeout_b");
    chk("t6_first_tid", q_tid[0], 0);
    chk("t6_first_data", q_data[0], 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
